imm_build_sequencer: RTL and testbench
======================================

Name: imm_build_sequencer

Overview:
- Micro-op sequencer in front of the Execute stage. Expands one "load 32-bit constant into rd" request into byte-insert micro-ops.
- Each micro-op is one use_imm operation: imm[7:0] is placed in byte lane shift_dist of operand a, and the other lanes are kept.
- Issues lanes in ascending order with a valid/ready handshake toward issue, with optional idle gaps for writeback/forwarding latency.
- Sits between decode and the Execute operand/immediate muxing.

Parameters:
- DATAW, 32, datapath width; fixed at 32 (4 byte lanes, 2-bit lane index).
- REGW, 5, register index width.
- ISSUE_GAP, 0, idle cycles inserted after each accepted micro-op except the last (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_rd  in  REGW  destination register
- req_value  in  DATAW  constant to build
- req_base  in  DATAW  current contents of rd
- uop_valid  out  1  micro-op present
- uop_ready  in  1  Execute/issue accepts micro-op
- uop_rd  out  REGW  destination (also operand-a source)
- uop_shift_dist  out  2  byte lane, 0 = bits 7:0
- uop_imm  out  11  {3'b000, lane byte}
- uop_use_imm  out  1  equals uop_valid
- uop_last  out  1  final micro-op of the request
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous and active-high on rst; the single clock is clk.
- Reset values: state IDLE, req_ready=1, uop_valid=0, uop_rd=0, uop_shift_dist=0, uop_imm=0, uop_use_imm=0, uop_last=0, busy=0, done=0, lane mask=0, gap counter=0.
- Request accept: req_valid && req_ready, which is only possible in IDLE. On accept, latch rd and value; lane mask bit i = (value byte i != base byte i).
- FSM states are IDLE, ISSUE and GAP.
- IDLE: on accept with a nonzero mask, go to ISSUE; uop_valid=1 from the next cycle (latency 1).
- IDLE: on accept with a zero mask, stay IDLE and pulse done the next cycle. No micro-op is issued.
- ISSUE: present the lowest set mask lane. uop_shift_dist = lane, uop_imm = {3'b0, value byte}, uop_last = 1 when exactly one mask bit remains.
- ISSUE: all uop_* outputs are registered and held stable while uop_valid && !uop_ready.
- ISSUE, on uop accept: clear that lane's mask bit.
  - If it was the last lane: go to IDLE, uop_valid=0 and done=1 in the next cycle; req_ready=1 in that same cycle.
  - Else if ISSUE_GAP>0: go to GAP, load counter = ISSUE_GAP, uop_valid=0.
  - Else: stay in ISSUE and present the next lane in the next cycle (back-to-back, one micro-op per cycle).
- GAP: decrement the counter each cycle. At 1, return to ISSUE, so the next uop_valid comes exactly ISSUE_GAP cycles after the accept cycle + 1.
- req_ready = (state == IDLE). A request can be accepted in the same cycle that done is high.
- done is asserted for exactly one cycle per request and never together with uop_valid.
- rst in any state (mid-issue, GAP, stalled) wins over everything: the sequence is dropped and all outputs take reset values in the next cycle. Partially written rd contents are not rolled back.
- uop_ready is ignored when uop_valid=0. req_* inputs are ignored when not in IDLE.

Optional Feature:
- Macro: IMMSEQ_SKIP_UNCHANGED_EN.
- Defined: lane mask as above; unchanged bytes are skipped.
- Undefined: mask is forced to 4'b1111, req_base is ignored, and every request issues exactly 4 micro-ops, lanes 0..3. The zero-mask path is unreachable.

Test Plan:
- Skip defined, ISSUE_GAP=0, uop_ready=1. Request rd=3, value 0x12345678, base 0, accepted at cycle t.
  - Micro-ops at t+1..t+4 with (lane, imm) = (0,0x078), (1,0x056), (2,0x034), (3,0x012).
  - uop_last only at t+4; done at t+5; busy high t+1..t+4.
- Skip defined. value 0x12345678, base 0x12FF5678 → single micro-op lane 2, imm 0x034, uop_last=1.
  - Same request with the macro undefined → 4 micro-ops as in the first scenario.
- Skip defined. value = base = 0xDEADBEEF → uop_valid never rises; done at t+1; req_ready stays 1; busy stays 0.
- Backpressure: uop_ready=0 for 3 cycles while lane 1 is presented → lane, imm, rd and last are unchanged across the stall. Lane 2 appears the cycle after the lane-1 accept.
- ISSUE_GAP=2, value 0xAABBCCDD, base 0 → uop_valid pulses at t+1, t+4, t+7, t+10; done at t+11.
- rst asserted after the lane-1 accept → next cycle uop_valid=0, busy=0, done=0, req_ready=1. A following request (value 0x000000FF, base 0, skip defined) issues lane 0, imm 0x0FF only.

Source files
------------

// File: rtl/imm_build_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_build_sequencer                                                      |
// | Expands a 32-bit constant load into per-byte use_imm insert micro-ops.   |
// | Option: IMMSEQ_SKIP_UNCHANGED_EN skips lanes whose byte already matches.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module imm_build_sequencer #(
  parameter int DATAW     = 32,
  parameter int REGW      = 5,
  parameter int ISSUE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [REGW-1:0]  req_rd,
  input  logic [DATAW-1:0] req_value,
  input  logic [DATAW-1:0] req_base,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [REGW-1:0]  uop_rd,
  output logic [1:0]       uop_shift_dist,
  output logic [10:0]      uop_imm,
  output logic             uop_use_imm,
  output logic             uop_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam logic [3:0] c_GAP_LOAD = 4'(ISSUE_GAP);

  state_e           state_q, state_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic [DATAW-1:0] value_q, value_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       gap_q, gap_d;
  logic             uop_valid_q, uop_valid_d;
  logic [1:0]       lane_q, lane_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [3:0]       w_req_mask;

`ifdef IMMSEQ_SKIP_UNCHANGED_EN
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_req_mask[i] = (req_value[8*i +: 8] != req_base[8*i +: 8]);
  end
`else
  logic w_base_unused;
  assign w_req_mask    = 4'b1111;
  assign w_base_unused = ^req_base;
`endif

  function automatic logic [1:0] f_low_lane(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd3;
    if (m[2]) l = 2'd2;
    if (m[1]) l = 2'd1;
    if (m[0]) l = 2'd0;
    return l;
  endfunction

  function automatic logic f_single(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    value_d = value_q;
    mask_d  = mask_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rd_d    = req_rd;
          value_d = req_value;
          mask_d  = w_req_mask;
          if (w_req_mask == 4'd0) done_d = 1'b1;
          else                    state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (uop_valid_q && uop_ready) begin
          // Clearing the lowest set bit retires the lane just accepted.
          mask_d = mask_q & (mask_q - 4'd1);
          if (mask_d == 4'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (ISSUE_GAP > 0) begin
            state_d = S_GAP;
            gap_d   = c_GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q == 4'd1) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from next state so they register cleanly.
    uop_valid_d = (state_d == S_ISSUE);
    lane_d      = uop_valid_d ? f_low_lane(mask_d) : 2'd0;
    byte_d      = uop_valid_d ? value_d[{lane_d, 3'b000} +: 8] : 8'd0;
    last_d      = uop_valid_d && f_single(mask_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      value_q     <= '0;
      mask_q      <= 4'd0;
      gap_q       <= 4'd0;
      uop_valid_q <= 1'b0;
      lane_q      <= 2'd0;
      byte_q      <= 8'd0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      value_q     <= value_d;
      mask_q      <= mask_d;
      gap_q       <= gap_d;
      uop_valid_q <= uop_valid_d;
      lane_q      <= lane_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign uop_valid      = uop_valid_q;
  assign uop_use_imm    = uop_valid_q;
  assign uop_rd         = rd_q;
  assign uop_shift_dist = lane_q;
  assign uop_imm        = {3'b000, byte_q};
  assign uop_last       = last_q;
  assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_build_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imm_build_sequencer                                                   |
// | Random + seeded stimulus for two sequencers (gap 0 and gap 2) vs model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_imm_build_sequencer;
  localparam int NCYC = 4000;
  localparam int GAP0 = 0;
  localparam int GAP1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [4:0]  req_rd    [2];
  logic [31:0] req_value [2];
  logic [31:0] req_base  [2];
  logic        uop_valid [2];
  logic        uop_ready [2];
  logic [4:0]  uop_rd    [2];
  logic [1:0]  uop_shift [2];
  logic [10:0] uop_imm   [2];
  logic        uop_use   [2];
  logic        uop_last  [2];
  logic        busy      [2];
  logic        done      [2];

  imm_build_sequencer #(.DATAW(32), .REGW(5), .ISSUE_GAP(GAP0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_rd(req_rd[0]), .req_value(req_value[0]), .req_base(req_base[0]),
    .uop_valid(uop_valid[0]), .uop_ready(uop_ready[0]), .uop_rd(uop_rd[0]),
    .uop_shift_dist(uop_shift[0]), .uop_imm(uop_imm[0]), .uop_use_imm(uop_use[0]),
    .uop_last(uop_last[0]), .busy(busy[0]), .done(done[0]));

  imm_build_sequencer #(.DATAW(32), .REGW(5), .ISSUE_GAP(GAP1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_rd(req_rd[1]), .req_value(req_value[1]), .req_base(req_base[1]),
    .uop_valid(uop_valid[1]), .uop_ready(uop_ready[1]), .uop_rd(uop_rd[1]),
    .uop_shift_dist(uop_shift[1]), .uop_imm(uop_imm[1]), .uop_use_imm(uop_use[1]),
    .uop_last(uop_last[1]), .busy(busy[1]), .done(done[1]));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each accepted request becomes a list of lanes to emit in order.
  bit          m_busy [2];
  bit          m_done [2];
  bit          m_rstd [2];
  int          m_wait [2];
  int          m_n    [2];
  int          m_pos  [2];
  int          m_lane [2][4];
  logic [31:0] m_val  [2];
  logic [4:0]  m_rd   [2];
  int          d_idx  [2];
  logic [31:0] d_val  [5];
  logic [31:0] d_base [5];

  function automatic int gap_of(input int k);
    return (k == 0) ? GAP0 : GAP1;
  endfunction

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_done[k] = 0; m_rstd[k] = 1;
    m_wait[k] = 0; m_n[k] = 0; m_pos[k] = 0;
  endtask

  task automatic compare(input int k);
    string       p;
    bit          ev;
    int          lane;
    logic [31:0] v;
    p  = $sformatf("gap%0d", gap_of(k));
    ev = m_busy[k] && (m_wait[k] == 0);
    chk({p, ".uop_valid"},   32'(uop_valid[k]), 32'(ev));
    chk({p, ".uop_use_imm"}, 32'(uop_use[k]),   32'(ev));
    chk({p, ".req_ready"},   32'(req_ready[k]), 32'(!m_busy[k]));
    chk({p, ".busy"},        32'(busy[k]),      32'(m_busy[k]));
    chk({p, ".done"},        32'(done[k]),      32'(m_done[k]));
    if (ev) begin
      lane = m_lane[k][m_pos[k]];
      v    = m_val[k] >> (8 * lane);
      chk({p, ".shift_dist"}, 32'(uop_shift[k]), 32'(lane));
      chk({p, ".imm"},        32'(uop_imm[k]),   {24'd0, v[7:0]});
      chk({p, ".last"},       32'(uop_last[k]),  32'(m_n[k] - m_pos[k] == 1));
      chk({p, ".rd"},         32'(uop_rd[k]),    32'(m_rd[k]));
    end else if (m_rstd[k]) begin
      chk({p, ".rst_shift"}, 32'(uop_shift[k]), 32'd0);
      chk({p, ".rst_imm"},   32'(uop_imm[k]),   32'd0);
      chk({p, ".rst_last"},  32'(uop_last[k]),  32'd0);
      chk({p, ".rst_rd"},    32'(uop_rd[k]),    32'd0);
    end
  endtask

  task automatic drive(input int k, input int cyc);
    logic [31:0] b;
    logic [31:0] v;
    rst[k]       = (cyc < 2) || ($urandom_range(99) < 2);
    req_valid[k] = ($urandom_range(3) != 0);
    req_rd[k]    = 5'($urandom_range(31));
    uop_ready[k] = (cyc < 60) ? 1'b1 : ($urandom_range(9) < 6);
    if (d_idx[k] < 5) begin
      rst[k]       = (cyc < 2);
      req_valid[k] = 1'b1;
      req_value[k] = d_val[d_idx[k]];
      req_base[k]  = d_base[d_idx[k]];
    end else begin
      b = $urandom;
      v = b;
      for (int j = 0; j < 4; j++)
        if ($urandom_range(1) == 1) v[8*j +: 8] = 8'($urandom_range(255));
      req_value[k] = v;
      req_base[k]  = b;
    end
  endtask

  task automatic update(input int k);
    bit dn;
    dn = 0;
    if (rst[k]) begin
      model_reset(k);
    end else begin
      m_rstd[k] = 0;
      if (m_busy[k]) begin
        if (m_wait[k] == 0) begin
          if (uop_ready[k]) begin
            m_pos[k]++;
            if (m_pos[k] == m_n[k]) begin
              m_busy[k] = 0;
              dn = 1;
            end else begin
              m_wait[k] = gap_of(k);
            end
          end
        end else begin
          m_wait[k]--;
        end
      end else if (req_valid[k]) begin
        if (d_idx[k] < 5) d_idx[k]++;
        m_rd[k]  = req_rd[k];
        m_val[k] = req_value[k];
        m_n[k]   = 0;
        m_pos[k] = 0;
        m_wait[k] = 0;
        for (int j = 0; j < 4; j++) begin
`ifdef IMMSEQ_SKIP_UNCHANGED_EN
          if (((req_value[k] >> (8 * j)) & 32'hFF) != ((req_base[k] >> (8 * j)) & 32'hFF))
`endif
          begin
            m_lane[k][m_n[k]] = j;
            m_n[k]++;
          end
        end
        if (m_n[k] == 0) dn = 1;
        else             m_busy[k] = 1;
      end
    end
    m_done[k] = dn;
  endtask

  initial begin
    d_val[0] = 32'h12345678; d_base[0] = 32'h00000000;
    d_val[1] = 32'h12345678; d_base[1] = 32'h12FF5678;
    d_val[2] = 32'hDEADBEEF; d_base[2] = 32'hDEADBEEF;
    d_val[3] = 32'hAABBCCDD; d_base[3] = 32'h00000000;
    d_val[4] = 32'h000000FF; d_base[4] = 32'h00000000;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_rd[k] = 5'd0;
      req_value[k] = 32'd0; req_base[k] = 32'd0; uop_ready[k] = 1'b1;
      d_idx[k] = 0;
      model_reset(k);
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        compare(k);
        drive(k, c);
        update(k);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
